// File: rtl/adsr_env_ctrl.sv
// ADSR envelope controller: turns note_on/note_off events into an 8-bit
// linear gain ramp that advances on codec sample ticks.
module adsr_env_ctrl #(
  parameter int A_DIV       = 19,
  parameter int D_DIV       = 19,
  parameter int R_DIV       = 19,
  parameter int SUSTAIN_LVL = 192
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       note_on,
  input  logic       note_off,
  output logic [7:0] env_gain,
  output logic [2:0] env_state,
  output logic       env_active,
  output logic       env_done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_e;

  localparam logic [15:0] A_LAST = 16'(A_DIV - 1);
  localparam logic [15:0] D_LAST = 16'(D_DIV - 1);
  localparam logic [15:0] R_LAST = 16'(R_DIV - 1);
  localparam logic [7:0]  SUS    = 8'(SUSTAIN_LVL);

  state_e      state_q, state_d;
  logic [7:0]  gain_q, gain_d;
  logic [15:0] div_q, div_d;
  logic        done_q, done_d;
  logic        active_q, active_d;
  logic [15:0] div_last;
  logic        step;
  logic        rel_ok;

  always_comb begin
    state_d  = state_q;
    gain_d   = gain_q;
    div_d    = div_q;
    done_d   = 1'b0;
    div_last = '0;
    unique case (state_q)
      ATTACK:  div_last = A_LAST;
      DECAY:   div_last = D_LAST;
      RELEASE: div_last = R_LAST;
      default: div_last = '0;
    endcase
    step   = sample_tick && (div_q == div_last);
    rel_ok = (state_q == ATTACK) || (state_q == DECAY) ||
             (state_q == SUSTAIN);

    if (note_on) begin
      // retrigger keeps the current gain so the ramp stays click-free
      state_d = ATTACK;
      div_d   = '0;
    end else if (note_off && rel_ok) begin
      state_d = RELEASE;
      div_d   = '0;
    end else begin
      unique case (state_q)
        ATTACK: begin
          if (gain_q == 8'hff) begin
            state_d = (SUS == 8'hff) ? SUSTAIN : DECAY;
            div_d   = '0;
          end else if (step) begin
            div_d  = '0;
            gain_d = gain_q + 8'd1;
          end else if (sample_tick) begin
            div_d = div_q + 16'd1;
          end
        end
        DECAY: begin
          if (gain_q <= SUS) begin
            state_d = SUSTAIN;
            div_d   = '0;
          end else if (step) begin
            div_d  = '0;
            gain_d = gain_q - 8'd1;
          end else if (sample_tick) begin
            div_d = div_q + 16'd1;
          end
        end
        RELEASE: begin
          if (gain_q == 8'h00) begin
            state_d = IDLE;
            div_d   = '0;
            done_d  = 1'b1;
          end else if (step) begin
            div_d  = '0;
            gain_d = gain_q - 8'd1;
          end else if (sample_tick) begin
            div_d = div_q + 16'd1;
          end
        end
        default: div_d = '0;
      endcase
    end
    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      gain_q   <= '0;
      div_q    <= '0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gain_q   <= gain_d;
      div_q    <= div_d;
      done_q   <= done_d;
      active_q <= active_d;
    end
  end

  assign env_gain   = gain_q;
  assign env_state  = state_q;
  assign env_active = active_q;
  assign env_done   = done_q;

endmodule

// File: tb/tb_adsr_env_ctrl.sv
// Directed bench for adsr_env_ctrl: three sustain levels share stimulus.
module tb_adsr_env_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sample_tick = 1'b0;
  logic note_on = 1'b0;
  logic note_off = 1'b0;

  logic [7:0] gain_m, gain_f, gain_z;
  logic [2:0] state_m, state_f, state_z;
  logic       act_m, act_f, act_z;
  logic       done_m, done_f, done_z;

  int n_chk = 0;
  int n_fail = 0;
  int done_m_cnt = 0;
  int done_z_cnt = 0;
  int base;

  always #5 clk = ~clk;

  adsr_env_ctrl #(.A_DIV(2), .D_DIV(2), .R_DIV(2), .SUSTAIN_LVL(192)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick),
    .note_on(note_on), .note_off(note_off),
    .env_gain(gain_m), .env_state(state_m),
    .env_active(act_m), .env_done(done_m)
  );

  adsr_env_ctrl #(.A_DIV(2), .D_DIV(2), .R_DIV(2), .SUSTAIN_LVL(255)) dut_f (
    .clk(clk), .reset(reset), .sample_tick(sample_tick),
    .note_on(note_on), .note_off(note_off),
    .env_gain(gain_f), .env_state(state_f),
    .env_active(act_f), .env_done(done_f)
  );

  adsr_env_ctrl #(.A_DIV(2), .D_DIV(2), .R_DIV(2), .SUSTAIN_LVL(0)) dut_z (
    .clk(clk), .reset(reset), .sample_tick(sample_tick),
    .note_on(note_on), .note_off(note_off),
    .env_gain(gain_z), .env_state(state_z),
    .env_active(act_z), .env_done(done_z)
  );

  always @(posedge clk) begin
    if (done_m === 1'b1) done_m_cnt <= done_m_cnt + 1;
    if (done_z === 1'b1) done_z_cnt <= done_z_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one-clock pulse of the given inputs, returns at the following negedge
  task automatic pulse(input logic on, input logic off, input logic tk);
    @(negedge clk);
    note_on = on;
    note_off = off;
    sample_tick = tk;
    @(negedge clk);
    note_on = 1'b0;
    note_off = 1'b0;
    sample_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // reset held 3 clks with note_on pulsing
    note_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      note_on = ~note_on;
      check_eq("rst_state", state_m, 0);
      check_eq("rst_gain", gain_m, 0);
      check_eq("rst_active", act_m, 0);
      check_eq("rst_done", done_m, 0);
    end
    reset = 1'b0;
    note_on = 1'b0;
    @(negedge clk);
    check_eq("post_rst_state", state_m, 0);
    check_eq("post_rst_gain", gain_m, 0);

    // full envelope
    pulse(1, 0, 0);
    check_eq("on_state", state_m, 1);
    check_eq("on_active", act_m, 1);
    check_eq("on_gain", gain_m, 0);
    ticks(1);
    check_eq("a_tick1", gain_m, 0);
    ticks(1);
    check_eq("a_tick2", gain_m, 1);
    ticks(508);
    check_eq("a_peak_gain", gain_m, 255);
    check_eq("a_peak_state", state_m, 2);
    ticks(126);
    check_eq("d_sus_gain", gain_m, 192);
    check_eq("d_sus_state", state_m, 3);
    ticks(1000);
    check_eq("sus_hold_gain", gain_m, 192);
    check_eq("sus_hold_state", state_m, 3);
    check_eq("no_early_done", done_m_cnt, 0);
    pulse(0, 1, 0);
    check_eq("off_state", state_m, 4);
    check_eq("off_gain", gain_m, 192);
    ticks(383);
    check_eq("rel_gain1", gain_m, 1);
    pulse(0, 0, 1);
    check_eq("rel_zero_gain", gain_m, 0);
    check_eq("rel_zero_state", state_m, 4);
    check_eq("rel_zero_done", done_m, 0);
    @(negedge clk);
    check_eq("idle_state", state_m, 0);
    check_eq("idle_done", done_m, 1);
    check_eq("idle_active", act_m, 0);
    @(negedge clk);
    check_eq("done_drop", done_m, 0);
    check_eq("done_count", done_m_cnt, 1);

    // retrigger during release
    pulse(1, 0, 0);
    ticks(636);
    check_eq("rt_sus", gain_m, 192);
    pulse(0, 1, 0);
    ticks(84);
    check_eq("rt_rel_gain", gain_m, 150);
    check_eq("rt_rel_state", state_m, 4);
    pulse(1, 0, 0);
    check_eq("rt_state", state_m, 1);
    check_eq("rt_gain", gain_m, 150);
    ticks(1);
    check_eq("rt_tick1", gain_m, 150);
    ticks(1);
    check_eq("rt_tick2", gain_m, 151);
    ticks(208);
    check_eq("rt_decay", state_m, 2);
    ticks(126);
    check_eq("rt_sus2_state", state_m, 3);
    check_eq("rt_sus2_gain", gain_m, 192);

    // simultaneous events
    pulse(1, 1, 0);
    check_eq("onoff_state", state_m, 1);
    check_eq("onoff_gain", gain_m, 192);
    ticks(1);
    check_eq("pre_sim_gain", gain_m, 192);
    pulse(1, 0, 1);
    check_eq("on_tick_gain", gain_m, 192);
    check_eq("on_tick_state", state_m, 1);
    ticks(1);
    check_eq("on_tick_t1", gain_m, 192);
    ticks(1);
    check_eq("on_tick_t2", gain_m, 193);
    @(negedge clk);
    reset = 1'b1;
    note_on = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    note_on = 1'b0;
    check_eq("rst_on_state", state_m, 0);
    check_eq("rst_on_gain", gain_m, 0);
    check_eq("rst_on_active", act_m, 0);

    // early release from attack
    base = done_m_cnt;
    pulse(1, 0, 0);
    ticks(80);
    check_eq("early_gain", gain_m, 40);
    check_eq("early_state", state_m, 1);
    pulse(0, 1, 0);
    check_eq("early_rel_state", state_m, 4);
    check_eq("early_rel_gain", gain_m, 40);
    ticks(80);
    @(negedge clk);
    check_eq("early_idle", state_m, 0);
    check_eq("early_zero", gain_m, 0);
    check_eq("early_done", done_m_cnt - base, 1);

    // sustain edge levels
    do_reset();
    base = done_z_cnt;
    pulse(1, 0, 0);
    ticks(510);
    check_eq("s255_state", state_f, 3);
    check_eq("s255_gain", gain_f, 255);
    check_eq("s0_mid_state", state_z, 2);
    ticks(510);
    check_eq("s0_state", state_z, 3);
    check_eq("s0_gain", gain_z, 0);
    check_eq("s0_active", act_z, 1);
    check_eq("s255_hold", gain_f, 255);
    pulse(0, 1, 0);
    check_eq("s0_rel", state_z, 4);
    @(negedge clk);
    check_eq("s0_idle", state_z, 0);
    check_eq("s0_done", done_z, 1);
    @(negedge clk);
    check_eq("s0_done_cnt", done_z_cnt - base, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
